display_sync_out: RTL

- Output stage directly downstream of the display datapath's frame mux.
- Consumes the serialized 8-bit frame byte stream (R, G, B order) and packs each byte triple into a 24-bit pixel held in a small pixel FIFO.
- Generates the panel timing (HSync, VSync, DE) from the same HB/VB/AIP/AIL configuration the controller uses.
- Drives aligned, registered RGB/sync outputs to the panel.

---
 rtl/display_pkg.sv | 25 ++
 rtl/pixel_fifo.sv | 55 +++++
 rtl/display_sync_out.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display output stage.
// Holds the pixel struct, packer states and the color-bar table.
package display_pkg;

  localparam int TW = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    WAIT_R = 2'd0,
    WAIT_G = 2'd1,
    WAIT_B = 2'd2
  } pack_state_e;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO; read data is the combinational head, 1-cycle write-to-read.
// Pushes are dropped when full and pops ignored when empty; same-cycle push+pop keeps count.
module pixel_fifo
  import display_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  pixel_t        wr_dat_i,
  input  logic          pop_i,
  output pixel_t        rd_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/display_sync_out.sv
// Packs R,G,B bytes into pixels and drives registered panel RGB/DE/HSync/VSync, 1 cycle after counter state.
// ByteReady drops when the pixel FIFO is full; DISPLAY_TEST_PATTERN_EN adds PatternSel color bars.
module display_sync_out
  import display_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HSYNC_W    = 8,
  parameter int VSYNC_W    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CSDisplay,
`ifdef DISPLAY_TEST_PATTERN_EN
  input  logic          PatternSel,
`endif
  input  logic [7:0]    FrameByte,
  input  logic          ByteValid,
  output logic          ByteReady,
  input  logic [TW-1:0] HBOut,
  input  logic [TW-1:0] VBOut,
  input  logic [TW-1:0] AIPOut,
  input  logic [TW-1:0] AILOut,
  output logic [23:0]   RGB,
  output logic          DE,
  output logic          HSync,
  output logic          VSync,
  output logic          Underflow
);

  localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [10:0] HSW = 11'(HSYNC_W);
  localparam logic [10:0] VSW = 11'(VSYNC_W);

  pack_state_e   state_q, state_d;
  logic [7:0]    r_q, r_d, g_q, g_d;
  logic          rdy_en_q, cs_q;
  logic [TW-1:0] hb_q, vb_q, aip_q, ail_q;
  logic [10:0]   h_q, h_d, v_q, v_d;
  pixel_t        rgb_q, rgb_d;
  logic          de_q, hs_q, vs_q, und_q, und_d;

  logic          accept_c, push_c, pop_c;
  pixel_t        push_dat_c, fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [10:0]   aip_x, ail_x, hb_x, vb_x, htot_c, vtot_c, hsw_c, vsw_c;
  logic          active_c, load_cfg_c, h_last_c, v_last_c, de_c, hs_c, vs_c;

  assign ByteReady  = rdy_en_q && (fifo_count != CW'(FIFO_DEPTH));
  assign accept_c   = ByteValid && ByteReady;
  assign push_dat_c = {r_q, g_q, FrameByte};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    push_c  = 1'b0;
    if (accept_c) begin
      case (state_q)
        WAIT_R:  begin r_d = FrameByte; state_d = WAIT_G; end
        WAIT_G:  begin g_d = FrameByte; state_d = WAIT_B; end
        WAIT_B:  begin push_c = !fifo_full; state_d = WAIT_R; end
        default: state_d = WAIT_R;
      endcase
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_i   (push_c),
    .wr_dat_i (push_dat_c),
    .pop_i    (pop_c),
    .rd_dat_o (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign aip_x  = {1'b0, aip_q};
  assign ail_x  = {1'b0, ail_q};
  assign hb_x   = {1'b0, hb_q};
  assign vb_x   = {1'b0, vb_q};
  assign htot_c = aip_x + hb_x;
  assign vtot_c = ail_x + vb_x;
  assign hsw_c  = (HSW < hb_x) ? HSW : hb_x;
  assign vsw_c  = (VSW < vb_x) ? VSW : vb_x;

  // Shadow config is only valid from the cycle after CSDisplay rises.
  assign active_c   = CSDisplay && cs_q;
  assign h_last_c   = (htot_c == '0) || (h_q == htot_c - 11'd1);
  assign v_last_c   = (vtot_c == '0) || (v_q == vtot_c - 11'd1);
  assign load_cfg_c = (CSDisplay && !cs_q) || (active_c && h_last_c && v_last_c);

  assign de_c = active_c && (h_q < aip_x) && (v_q < ail_x);
  assign hs_c = active_c && (h_q >= aip_x) && (h_q < aip_x + hsw_c);
  assign vs_c = active_c && (v_q >= ail_x) && (v_q < ail_x + vsw_c);

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (active_c) begin
      if (h_last_c) begin
        v_d = v_last_c ? 11'd0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
        v_d = v_q;
      end
    end
  end

`ifdef DISPLAY_TEST_PATTERN_EN
  logic [2:0]  bar_c;
  logic [13:0] h8_c;
  // Bar k starts where 8*h reaches k*AIP; thresholds are monotonic so the last hit wins.
  always_comb begin
    bar_c = '0;
    h8_c  = {h_q, 3'b000};
    for (int k = 1; k < 8; k++) begin
      if (h8_c >= 14'(k) * {4'b0000, aip_q}) bar_c = 3'(k);
    end
  end
`endif

  always_comb begin
    rgb_d = '0;
    pop_c = 1'b0;
    und_d = und_q;
    if (de_c) begin
`ifdef DISPLAY_TEST_PATTERN_EN
      if (PatternSel) rgb_d = BAR_COLORS[bar_c];
      else
`endif
      if (!fifo_empty) begin
        pop_c = 1'b1;
        rgb_d = fifo_head;
      end else begin
        und_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= WAIT_R;
      r_q      <= '0;
      g_q      <= '0;
      rdy_en_q <= 1'b0;
      cs_q     <= 1'b0;
      hb_q     <= '0;
      vb_q     <= '0;
      aip_q    <= '0;
      ail_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      g_q      <= g_d;
      rdy_en_q <= 1'b1;
      cs_q     <= CSDisplay;
      if (load_cfg_c) begin
        hb_q  <= HBOut;
        vb_q  <= VBOut;
        aip_q <= AIPOut;
        ail_q <= AILOut;
      end
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
      de_q  <= de_c;
      hs_q  <= hs_c;
      vs_q  <= vs_c;
      und_q <= und_d;
    end
  end

  assign RGB       = rgb_q;
  assign DE        = de_q;
  assign HSync     = hs_q;
  assign VSync     = vs_q;
  assign Underflow = und_q;

endmodule
